// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter
// Shares one status LED between four owners (IDLE, BUSY, DONE, ERR) by fixed
// priority. A free-running tick divider paces every blink pattern; all
// outputs come straight from flops.
module led_blink_arbiter #(
   parameter logic [24:0] TICK_DIV = 25'd12_500_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       err_req,
   input  logic       busy_req,
   input  logic       done_pulse,
   input  logic [3:0] done_count,
   output logic       led,
   output logic [1:0] grant,
   output logic       done_ack,
   output logic       done_ovf
);

   // Encoding doubles as the grant output value.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10,
      ST_ERR  = 2'b11
   } state_t;

   state_t      state_q, state_d;
   logic [24:0] cnt_q, cnt_d;
   logic        tick;
   logic        led_q, led_d;
   logic [1:0]  phase_q, phase_d;
   logic        pend_q, pend_d;
   logic [3:0]  rem_q, rem_d;
   logic        ack_q, ack_d;
   logic        ovf_q, ovf_d;

   // Free-running tick divider; deliberately independent of the arbiter state
   // so blink cadence never drifts when owners change.
   always_comb begin
      tick  = (cnt_q == TICK_DIV - 25'd1);
      cnt_d = tick ? 25'd0 : cnt_q + 25'd1;
   end

   // Fixed-priority arbitration: error, then a pending completion, then busy.
   always_comb begin
      state_d = ST_IDLE;
      if (err_req) begin
         state_d = ST_ERR;
      end else if (pend_q) begin
         state_d = ST_DONE;
      end else if (busy_req) begin
         state_d = ST_BUSY;
      end
   end

   // Blink patterns and completion bookkeeping; a state change always wins
   // over a coincident tick so every new owner starts from a dark LED.
   always_comb begin
      led_d   = led_q;
      phase_d = phase_q;
      pend_d  = pend_q;
      rem_d   = rem_q;
      ack_d   = 1'b0;
      ovf_d   = 1'b0;

      if (state_d != state_q) begin
         led_d   = 1'b0;
         phase_d = 2'd0;
      end else if (tick) begin
         case (state_q)
            ST_ERR: begin
               led_d = ~led_q;
            end
            ST_BUSY: begin
               phase_d = phase_q + 2'd1;
               if (phase_q == 2'd3) begin
                  led_d = ~led_q;
               end
            end
            ST_DONE: begin
               led_d = ~led_q;
               // A falling LED closes one blink of the completion sequence.
               if (led_q) begin
                  rem_d = rem_q - 4'd1;
                  if (rem_q == 4'd1) begin
                     ack_d  = 1'b1;
                     pend_d = 1'b0;
                  end
               end
            end
            default: begin
            end
         endcase
      end

      // Only one completion may be outstanding; extra pulses are reported
      // and dropped without disturbing the count in progress.
      if (done_pulse) begin
         if (pend_q) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = 1'b1;
            rem_d  = (done_count == 4'd0) ? 4'd1 : done_count;
         end
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 25'd0;
         led_q   <= 1'b0;
         phase_q <= 2'd0;
         pend_q  <= 1'b0;
         rem_q   <= 4'd0;
         ack_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         led_q   <= led_d;
         phase_q <= phase_d;
         pend_q  <= pend_d;
         rem_q   <= rem_d;
         ack_q   <= ack_d;
         ovf_q   <= ovf_d;
      end
   end

   assign led      = led_q;
   assign grant    = state_q;
   assign done_ack = ack_q;
   assign done_ovf = ovf_q;

endmodule

// File: doc/led_blink_arbiter.md
LED_BLINK_ARBITER -- requirements
Module: led_blink_arbiter

Interface
REQ-001 SHALL have parameter: TICK_DIV, default 25'd12_500_000, clock cycles per blink tick (legal range 2..2^25-1).
REQ-002 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: err_req  input  1  level request, error indication.
REQ-005 SHALL have port: busy_req  input  1  level request, busy indication.
REQ-006 SHALL have port: done_pulse  input  1  one-cycle request, completion indication.
REQ-007 SHALL have port: done_count  input  4  blink count, sampled only when done_pulse=1.
REQ-008 SHALL have port: led  output  1  registered LED drive.
REQ-009 SHALL have port: grant  output  2  registered owner: 00 IDLE, 01 BUSY, 10 DONE, 11 ERR.
REQ-010 SHALL have port: done_ack  output  1  one-cycle pulse when a DONE sequence completes.
REQ-011 SHALL have port: done_ovf  output  1  one-cycle pulse when a done_pulse is dropped.

Function
REQ-012 SHALL run a 25-bit tick counter 0..TICK_DIV-1 that wraps; tick=1 in the cycle the counter equals TICK_DIV-1; the counter never resets on state change.
REQ-013 SHALL hold state IDLE, BUSY, DONE, ERR; grant equals the current state encoding.
REQ-014 SHALL evaluate next state every cycle by fixed priority: err_req -> ERR; else done pending -> DONE; else busy_req -> BUSY; else IDLE.
REQ-015 SHALL, on done_pulse with no done pending, set pending and load remaining = done_count, treating done_count=0 as 1.
REQ-016 SHALL, on done_pulse while pending is set (including during DONE or while preempted), ignore the pulse, keep the remaining count, and assert done_ovf for one cycle on the following edge.
REQ-017 SHALL, on any state change, drive led=0 and clear the 2-bit phase counter at the same edge.
REQ-018 SHALL leave led at 0 in IDLE.
REQ-019 SHALL, in ERR, toggle led on every tick.
REQ-020 SHALL, in BUSY, increment the phase counter on each tick and toggle led when the phase wraps 3->0 (every 4 ticks).
REQ-021 SHALL, in DONE, toggle led on each tick, decrementing remaining on each tick where led falls 1->0.
REQ-022 SHALL, when that decrement reaches 0, assert done_ack for that same edge's cycle, clear pending, and re-arbitrate on the next edge.
REQ-023 SHALL, when ERR preempts DONE, retain remaining and pending; on resume DONE restarts with led=0 and the remaining count intact.
REQ-024 SHALL suppress blink activity but not tick counting when the tick and a state change coincide: the state change wins, so led=0.
REQ-025 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, set led=0, grant=00, done_ack=0, done_ovf=0, tick counter=0, phase=0, pending=0, remaining=0.
REQ-027 SHALL, when reset is applied mid-sequence, abort any DONE sequence with no done_ack; requests present after release are arbitrated at the first edge with rst_n=1.

Verification (TICK_DIV=4)
REQ-028 SHALL verify: err_req=1 held -> grant=11 after one edge; led toggles every 4 clocks; led high for exactly 4 clocks per period.
REQ-029 SHALL verify: done_pulse with done_count=3, others low -> exactly 3 led high intervals of 4 clocks; done_ack single-cycle on the 3rd falling edge; grant 10->00 on the next edge.
REQ-030 SHALL verify: busy_req=1, err_req pulsed high for 10 clocks -> grant 01->11->01; led=0 at each transition edge; BUSY toggles 16 clocks after resume.
REQ-031 SHALL verify: done_count=3 sequence, err_req asserted after the 1st blink and released later -> 2 further blinks after resume, then done_ack.
REQ-032 SHALL verify: second done_pulse (done_count=7) during an active DONE -> done_ovf one pulse; total blinks still equal the first count; done_count=0 request -> exactly 1 blink.
REQ-033 SHALL verify: rst_n=0 for 2 clocks mid-DONE with led=1 -> led=0, grant=00, no done_ack; a subsequent done_pulse is accepted normally.
